// File: rtl/dmem_arb_pkg.sv
// Shared constants for the two-requester data-RAM arbiter.
package dmem_arb_pkg;

    localparam int   WIDTH_DEF  = 32;
    localparam int   ADDR_W_DEF = 5;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_DBG  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant; the requester that did not win last time wins a tie.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic gnt0,
    output logic gnt1
);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && (!req1 || last_owner == OWNER_DBG)) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the core LSU (0) and the debug/loader port (1),
// with a registered issue stage and registered read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [WIDTH-1:0]  wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [WIDTH-1:0]  rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata1,

    output logic [WIDTH-1:0]  ram_a,
    output logic [WIDTH-1:0]  ram_wd,
    output logic              ram_we,
    input  logic [WIDTH-1:0]  ram_rd
);

    logic              arb_gnt0, arb_gnt1;
    logic              last_owner_q, last_owner_d;
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic [WIDTH-1:0]  rdata0_q, rdata0_d;
    logic [WIDTH-1:0]  rdata1_q, rdata1_d;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner_q),
        .gnt0       (arb_gnt0),
        .gnt1       (arb_gnt1)
    );

    // Grants are masked during reset so no requester believes its command was taken.
    assign gnt0 = arb_gnt0 & rst;
    assign gnt1 = arb_gnt1 & rst;

    always_comb begin
        valid_d      = gnt0 | gnt1;
        we_d         = we_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_owner_d = last_owner_q;
        if (gnt0) begin
            we_d         = we0;
            owner_d      = OWNER_CORE;
            addr_d       = addr0;
            wdata_d      = wdata0;
            last_owner_d = OWNER_CORE;
        end else if (gnt1) begin
            we_d         = we1;
            owner_d      = OWNER_DBG;
            addr_d       = addr1;
            wdata_d      = wdata1;
            last_owner_d = OWNER_DBG;
        end
    end

    // Read data is captured from the RAM during the issue cycle and steered to its owner.
    always_comb begin
        rvalid0_d = valid_q & ~we_q & (owner_q == OWNER_CORE);
        rvalid1_d = valid_q & ~we_q & (owner_q == OWNER_DBG);
        rdata0_d  = rvalid0_d ? ram_rd : rdata0_q;
        rdata1_d  = rvalid1_d ? ram_rd : rdata1_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWNER_DBG;
            valid_q      <= 1'b0;
            we_q         <= 1'b0;
            owner_q      <= OWNER_CORE;
            addr_q       <= '0;
            wdata_q      <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            valid_q      <= valid_d;
            we_q         <= we_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ram_a   = WIDTH'(addr_q);
    assign ram_wd  = wdata_q;
    assign ram_we  = valid_q & we_q;
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;

endmodule
